// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment driver.
//   SEG_W     : segments per digit (a..g)
//   seg_t     : one digit's segment pattern, bit0 = segment a, 1 = lit
//   apply_pol : converts a lit-high vector to pin polarity
package sevenseg_pkg;

  localparam int SEG_W = 7;

  // Widest vector apply_pol handles; callers zero-extend and truncate back.
  localparam int MAX_POL_W = 32;

  typedef logic [SEG_W-1:0] seg_t;

  // Lit-high in, pin level out: active-low pins get the bitwise inverse.
  function automatic logic [MAX_POL_W-1:0] apply_pol(input logic [MAX_POL_W-1:0] v,
                                                    input bit active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/sevenseg_mux_driver_if.sv
// Bundle between display-formatting logic (master) and the scan driver (slave).
//   digit_segments : 7 bits per digit, digit i at [7i+6:7i], 1 = lit
//   digit_dp       : decimal point per digit, 1 = lit
//   digit_blank    : 1 = digit never driven
//   brightness     : 0 = off, all-ones = full
//   segments/dp    : segment pins, pin polarity
//   anodes         : digit selects, pin polarity
//   frame_start    : one-cycle pulse on the first output cycle of digit 0's slot
// Transfer contract: there is no valid/ready pair. The master holds the
// digit_* and brightness levels steady; the slave samples all of them together
// in the last cycle of each frame, so a value is accepted exactly when it is
// present in that cycle and is shown for the whole following frame.
// frame_start tells the master when a new frame has begun.
interface sevenseg_mux_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  import sevenseg_pkg::*;

  logic [SEG_W*NUM_DIGITS-1:0] digit_segments;
  logic [NUM_DIGITS-1:0]       digit_dp;
  logic [NUM_DIGITS-1:0]       digit_blank;
  logic [BRIGHT_W-1:0]         brightness;
  seg_t                        segments;
  logic                        dp;
  logic [NUM_DIGITS-1:0]       anodes;
  logic                        frame_start;

  modport master (
    output digit_segments, digit_dp, digit_blank, brightness,
    input  segments, dp, anodes, frame_start
  );

  modport slave (
    input  digit_segments, digit_dp, digit_blank, brightness,
    output segments, dp, anodes, frame_start
  );

endinterface

// File: rtl/sevenseg_scan_timer.sv
// Scan counter chain: sub (0..SUB_DIV-1) -> phase (0..2**BRIGHT_W-1)
// -> idx (0..NUM_DIGITS-1). Each stage wraps to 0 and carries into the next.
//   clk, rst     : clock, synchronous active-high reset (all counters to 0)
//   idx_o        : digit currently being scanned
//   phase_o      : brightness phase within the digit's slot
//   sub_zero_o   : sub counter is 0
//   frame_end_o  : all three counters at their maximum (last cycle of a frame)
module sevenseg_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int SUB_DIV    = 2,
  parameter int BRIGHT_W   = 4,
  localparam int IDX_W     = $clog2(NUM_DIGITS),
  localparam int SUB_W     = $clog2(SUB_DIV)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [IDX_W-1:0]    idx_o,
  output logic [BRIGHT_W-1:0] phase_o,
  output logic                sub_zero_o,
  output logic                frame_end_o
);

  logic [SUB_W-1:0]    sub_q,   sub_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic                sub_max, phase_max, idx_max;

  assign sub_max   = (sub_q == SUB_W'(SUB_DIV - 1));
  assign phase_max = &phase_q;
  assign idx_max   = (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    sub_d   = sub_max ? '0 : sub_q + 1'b1;
    // phase spans a full power of two, so plain increment wraps correctly.
    phase_d = sub_max ? phase_q + 1'b1 : phase_q;
    idx_d   = idx_q;
    if (sub_max && phase_max) begin
      idx_d = idx_max ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_o       = idx_q;
  assign phase_o     = phase_q;
  assign sub_zero_o  = (sub_q == '0);
  assign frame_end_o = sub_max && phase_max && idx_max;

endmodule

// File: rtl/sevenseg_mux_driver.sv
// N-digit multiplexed seven-segment driver with decimal points, per-digit
// blanking, frame-synchronous shadow loading, PWM brightness and a one-cycle
// anti-ghost dead time at the start of every digit slot.
//   clk, rst : clock, synchronous active-high reset
//   disp_if  : slave side of sevenseg_mux_driver_if (digit data in, pins out)
// All pin outputs are registered one cycle after the counter state they show.
module sevenseg_mux_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SUB_DIV        = 2,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
  input logic                   clk,
  input logic                   rst,
  sevenseg_mux_driver_if.slave  disp_if
);

  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] phase;
  logic                sub_zero;
  logic                frame_end;

  sevenseg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SUB_DIV    (SUB_DIV),
    .BRIGHT_W   (BRIGHT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .idx_o       (idx),
    .phase_o     (phase),
    .sub_zero_o  (sub_zero),
    .frame_end_o (frame_end)
  );

  // Shadow copies: loaded only in the last cycle of a frame so a whole frame
  // is always drawn from one consistent snapshot. Reset gives a blank frame.
  logic [SEG_W*NUM_DIGITS-1:0] seg_sh_q;
  logic [NUM_DIGITS-1:0]       dp_sh_q;
  logic [NUM_DIGITS-1:0]       blank_sh_q;
  logic [BRIGHT_W-1:0]         bright_sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_sh_q    <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= '0;
      bright_sh_q <= '0;
    end else if (frame_end) begin
      seg_sh_q    <= disp_if.digit_segments;
      dp_sh_q     <= disp_if.digit_dp;
      blank_sh_q  <= disp_if.digit_blank;
      bright_sh_q <= disp_if.brightness;
    end
  end

  // Active decode for the digit under scan.
  logic                  in_pwm, dead, active;
  seg_t                  seg_sel;
  seg_t                  seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  always_comb begin
    seg_sel = seg_sh_q[SEG_W*int'(idx) +: SEG_W];
    // Full brightness keeps the digit lit across every phase; otherwise lit
    // while phase is below the level.
    in_pwm  = (&bright_sh_q) || (phase < bright_sh_q);
    // First cycle of every slot is dark so the previous digit's segments do
    // not ghost onto the newly selected anode.
    dead    = (phase == '0) && sub_zero;
    active  = !blank_sh_q[idx] && in_pwm && !dead;

    seg_d = SEG_W'(apply_pol(MAX_POL_W'(active ? seg_sel : '0), SEG_ACTIVE_LOW != 0));
    dp_d  = 1'(apply_pol(MAX_POL_W'(active && dp_sh_q[idx]), SEG_ACTIVE_LOW != 0));
    an_d  = NUM_DIGITS'(apply_pol(MAX_POL_W'(active ? (NUM_DIGITS'(1) << idx) : '0),
                                  AN_ACTIVE_LOW != 0));
  end

  seg_t                  segments_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] anodes_q;
  logic                  start_pend_q;
  logic                  frame_start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      segments_q    <= SEG_W'(apply_pol('0, SEG_ACTIVE_LOW != 0));
      dp_q          <= 1'(apply_pol('0, SEG_ACTIVE_LOW != 0));
      anodes_q      <= NUM_DIGITS'(apply_pol('0, AN_ACTIVE_LOW != 0));
      start_pend_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      segments_q    <= seg_d;
      dp_q          <= dp_d;
      anodes_q      <= an_d;
      // frame_end -> counters at zero next cycle -> outputs show that state
      // one cycle later. Deriving the pulse from frame_end rather than from
      // the zero state keeps the dark post-reset frame from announcing itself.
      start_pend_q  <= frame_end;
      frame_start_q <= start_pend_q;
    end
  end

  assign disp_if.segments    = segments_q;
  assign disp_if.dp          = dp_q;
  assign disp_if.anodes      = anodes_q;
  assign disp_if.frame_start = frame_start_q;

endmodule
